regfile_arbiter: RTL and testbench

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

---
 rtl/regfile_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_regfile_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - two-requester round-robin arbiter driving a register file
//
// Purpose: arbitrates between requester A (core) and requester B (debug) for
// a single register file. A granted command spends one ISSUE cycle on the
// register-file ports; reads return captured data one cycle later.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   a_req/b_req                   request, held high until ack
//   a_op/b_op [1:0]               00 write, 01 inc, 10 dec, 11 read
//   a_sel/b_sel [3:0]             target register index
//   a_wdata/b_wdata [7:0]         write data (op 00 only)
//   a_ack/b_ack                   one-cycle pulse, command on rf ports
//   a_rvalid/b_rvalid             one-cycle pulse, rdata valid
//   rdata [7:0]                   captured read data (shared)
//   rf_inSelect, rf_in, rf_write_en       register-file write port
//   rf_incSelect, rf_inc, rf_dec          register-file inc/dec port
//   rf_outAselect, rf_outA                register-file read port A

module regfile_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_req,
  input  logic [1:0] a_op,
  input  logic [3:0] a_sel,
  input  logic [7:0] a_wdata,
  input  logic       b_req,
  input  logic [1:0] b_op,
  input  logic [3:0] b_sel,
  input  logic [7:0] b_wdata,
  output logic       a_ack,
  output logic       b_ack,
  output logic       a_rvalid,
  output logic       b_rvalid,
  output logic [7:0] rdata,
  output logic [3:0] rf_inSelect,
  output logic [7:0] rf_in,
  output logic       rf_write_en,
  output logic [3:0] rf_incSelect,
  output logic       rf_inc,
  output logic       rf_dec,
  output logic [3:0] rf_outAselect,
  input  logic [7:0] rf_outA
);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_INC   = 2'b01;
  localparam logic [1:0] OP_DEC   = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [1:0] r_op;
  logic       r_from_b;
  // 1: B wins a tie on the next contended grant; reset value favours A.
  logic       r_prio_b;

  logic       w_grant_a;
  logic       w_grant_b;
  logic       w_grant;
  logic [1:0] w_op;
  logic [3:0] w_sel;
  logic [7:0] w_wdata;

  // Requests are only looked at in IDLE, so a requester still holding req
  // during its ack cycle cannot be granted twice for one command.
  always_comb begin
    w_state_next = r_state;
    w_grant_a    = 1'b0;
    w_grant_b    = 1'b0;
    case (r_state)
      IDLE: begin
        if (a_req && (!b_req || !r_prio_b)) begin
          w_grant_a = 1'b1;
        end else if (b_req) begin
          w_grant_b = 1'b1;
        end
        if (a_req || b_req) begin
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign w_grant = w_grant_a | w_grant_b;

  always_comb begin
    w_op    = a_op;
    w_sel   = a_sel;
    w_wdata = a_wdata;
    if (w_grant_b) begin
      w_op    = b_op;
      w_sel   = b_sel;
      w_wdata = b_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // All rf-facing outputs are registered: they are loaded on the granting
  // edge so they are valid for exactly the ISSUE cycle. Strobes, acks and
  // rvalids default low every cycle; selects and rf_in hold their value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op          <= OP_WRITE;
      r_from_b      <= 1'b0;
      r_prio_b      <= 1'b0;
      a_ack         <= 1'b0;
      b_ack         <= 1'b0;
      a_rvalid      <= 1'b0;
      b_rvalid      <= 1'b0;
      rdata         <= 8'h00;
      rf_inSelect   <= 4'h0;
      rf_in         <= 8'h00;
      rf_write_en   <= 1'b0;
      rf_incSelect  <= 4'h0;
      rf_inc        <= 1'b0;
      rf_dec        <= 1'b0;
      rf_outAselect <= 4'h0;
    end else begin
      rf_write_en <= 1'b0;
      rf_inc      <= 1'b0;
      rf_dec      <= 1'b0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      a_rvalid    <= 1'b0;
      b_rvalid    <= 1'b0;

      if (w_grant) begin
        r_op     <= w_op;
        r_from_b <= w_grant_b;
        // Granting A hands the next tie to B, and vice versa.
        r_prio_b <= w_grant_a;
        a_ack    <= w_grant_a;
        b_ack    <= w_grant_b;
        case (w_op)
          OP_WRITE: begin
            rf_write_en <= 1'b1;
            rf_inSelect <= w_sel;
            rf_in       <= w_wdata;
          end
          OP_INC: begin
            rf_inc       <= 1'b1;
            rf_incSelect <= w_sel;
          end
          OP_DEC: begin
            rf_dec       <= 1'b1;
            rf_incSelect <= w_sel;
          end
          OP_READ: begin
            rf_outAselect <= w_sel;
          end
        endcase
      end

      // rf_outA is combinational off rf_outAselect, which was loaded on the
      // granting edge, so it is settled by the end of the ISSUE cycle.
      if (r_state == ISSUE && r_op == OP_READ) begin
        rdata    <= rf_outA;
        a_rvalid <= !r_from_b;
        b_rvalid <= r_from_b;
      end
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - scoreboard bench for regfile_arbiter

module tb_regfile_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_req, b_req;
  logic [1:0] a_op, b_op;
  logic [3:0] a_sel, b_sel;
  logic [7:0] a_wdata, b_wdata;
  logic       a_ack, b_ack, a_rvalid, b_rvalid;
  logic [7:0] rdata;
  logic [3:0] rf_inSelect, rf_incSelect, rf_outAselect;
  logic [7:0] rf_in, rf_outA;
  logic       rf_write_en, rf_inc, rf_dec;

  typedef struct packed {
    logic       who;
    logic [1:0] op;
    logic [3:0] sel;
    logic [7:0] wdata;
  } cmd_t;

  cmd_t       exp_q[$];
  logic [7:0] rd_q[$];
  int         n_pass = 0;
  int         n_total = 0;

  logic [7:0] rf_mem [16];

  regfile_arbiter dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_op(a_op), .a_sel(a_sel), .a_wdata(a_wdata),
    .b_req(b_req), .b_op(b_op), .b_sel(b_sel), .b_wdata(b_wdata),
    .a_ack(a_ack), .b_ack(b_ack), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .rdata(rdata),
    .rf_inSelect(rf_inSelect), .rf_in(rf_in), .rf_write_en(rf_write_en),
    .rf_incSelect(rf_incSelect), .rf_inc(rf_inc), .rf_dec(rf_dec),
    .rf_outAselect(rf_outAselect), .rf_outA(rf_outA)
  );

  always #5 clk = ~clk;

  // Register file model: r1 starts at 0xFF and r2 at 0x00 to exercise wrap.
  assign rf_outA = rf_mem[rf_outAselect];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= (i == 1) ? 8'hFF : 8'h00;
    end else begin
      if (rf_write_en) rf_mem[rf_inSelect] <= rf_in;
      if (rf_inc) rf_mem[rf_incSelect] <= rf_mem[rf_incSelect] + 8'd1;
      if (rf_dec) rf_mem[rf_incSelect] <= rf_mem[rf_incSelect] - 8'd1;
    end
  end

  task automatic idle_inputs();
    a_req = 1'b0; a_op = 2'b00; a_sel = 4'h0; a_wdata = 8'h00;
    b_req = 1'b0; b_op = 2'b00; b_sel = 4'h0; b_wdata = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    n_total++;
    if ({rf_write_en, rf_inc, rf_dec, a_ack, b_ack, a_rvalid, b_rvalid} !== 7'b0)
      $display("FAIL reset_strobes got %b want 0000000",
               {rf_write_en, rf_inc, rf_dec, a_ack, b_ack, a_rvalid, b_rvalid});
    else n_pass++;
    n_total++;
    if ({rf_inSelect, rf_incSelect, rf_outAselect} !== 12'h000)
      $display("FAIL reset_selects got %h want 000", {rf_inSelect, rf_incSelect, rf_outAselect});
    else n_pass++;
    n_total++;
    if ({rf_in, rdata} !== 16'h0000)
      $display("FAIL reset_data got %h want 0000", {rf_in, rdata});
    else n_pass++;
  endtask

  // Both requesters asserted from reset: A inc r1, B dec r2.
  task automatic test_contention();
    logic [1:0] exp_ack;
    logic [2:0] exp_str;
    rst = 1'b1;
    a_req = 1'b1; a_op = 2'b01; a_sel = 4'd1;
    b_req = 1'b1; b_op = 2'b10; b_sel = 4'd2;
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      exp_q.push_back(i[0] ? cmd_t'{1'b1, 2'b10, 4'd2, 8'h00} : cmd_t'{1'b0, 2'b01, 4'd1, 8'h00});
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp_ack = (k % 2 == 1) ? ((k % 4 == 1) ? 2'b10 : 2'b01) : 2'b00;
      n_total++;
      if ({a_ack, b_ack} !== exp_ack)
        $display("FAIL contention_ack cycle %0d got %b want %b", k, {a_ack, b_ack}, exp_ack);
      else n_pass++;
      if (a_ack || b_ack) begin
        cmd_t c;
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL contention_extra_ack cycle %0d got ack want none", k);
        end else begin
          c = exp_q.pop_front();
          exp_str = (c.op == 2'b00) ? 3'b100 : (c.op == 2'b01) ? 3'b010 :
                    (c.op == 2'b10) ? 3'b001 : 3'b000;
          if ({b_ack, rf_write_en, rf_inc, rf_dec, rf_incSelect} !== {c.who, exp_str, c.sel})
            $display("FAIL contention_cmd cycle %0d got %b want %b", k,
                     {b_ack, rf_write_en, rf_inc, rf_dec, rf_incSelect}, {c.who, exp_str, c.sel});
          else n_pass++;
        end
      end
      if (k == 8) begin
        a_req = 1'b0;
        b_req = 1'b0;
      end
    end
    n_total++;
    if (exp_q.size() != 0) $display("FAIL contention_missing got %0d left want 0", exp_q.size());
    else n_pass++;
    exp_q.delete();
    @(negedge clk);
    n_total++;
    if ({rf_mem[1], rf_mem[2]} !== 16'h01FE)
      $display("FAIL contention_wrap got %h want 01fe", {rf_mem[1], rf_mem[2]});
    else n_pass++;
  endtask

  task automatic test_single_write();
    int   lat;
    logic got;
    cmd_t c;
    @(negedge clk);
    a_req = 1'b1; a_op = 2'b00; a_sel = 4'd3; a_wdata = 8'h5A;
    exp_q.push_back(cmd_t'{1'b0, 2'b00, 4'd3, 8'h5A});
    lat = 0; got = 1'b0;
    while (!got && lat < 5) begin
      @(negedge clk);
      lat++;
      if (a_ack || b_ack) got = 1'b1;
    end
    n_total++;
    if (!got || lat != 1) $display("FAIL write_latency got %0d (ack %b) want 1", lat, got);
    else n_pass++;
    if (got && exp_q.size() != 0) begin
      c = exp_q.pop_front();
      n_total++;
      if ({a_ack, b_ack, rf_write_en, rf_inc, rf_dec, rf_inSelect, rf_in} !==
          {~c.who, c.who, 3'b100, c.sel, c.wdata})
        $display("FAIL write_issue got %h want %h",
                 {a_ack, b_ack, rf_write_en, rf_inc, rf_dec, rf_inSelect, rf_in},
                 {~c.who, c.who, 3'b100, c.sel, c.wdata});
      else n_pass++;
    end
    exp_q.delete();
    a_req = 1'b0;
    @(negedge clk);
    n_total++;
    if ({rf_write_en, rf_inc, rf_dec, a_ack, b_ack} !== 5'b0)
      $display("FAIL write_after got %b want 00000", {rf_write_en, rf_inc, rf_dec, a_ack, b_ack});
    else n_pass++;
    n_total++;
    if (rf_mem[3] !== 8'h5A) $display("FAIL write_stored got %h want 5a", rf_mem[3]);
    else n_pass++;
  endtask

  task automatic test_read();
    cmd_t c;
    // Preload r7 = 0xC3 through requester A.
    @(negedge clk);
    a_req = 1'b1; a_op = 2'b00; a_sel = 4'd7; a_wdata = 8'hC3;
    @(negedge clk);
    a_req = 1'b0;
    n_total++;
    if (a_ack !== 1'b1) $display("FAIL read_preload_ack got %b want 1", a_ack);
    else n_pass++;
    @(negedge clk);
    b_req = 1'b1; b_op = 2'b11; b_sel = 4'd7;
    exp_q.push_back(cmd_t'{1'b1, 2'b11, 4'd7, 8'h00});
    rd_q.push_back(8'hC3);
    @(negedge clk);
    n_total++;
    if ({a_ack, b_ack, rf_write_en, rf_inc, rf_dec} !== 5'b01000)
      $display("FAIL read_ack got %b want 01000", {a_ack, b_ack, rf_write_en, rf_inc, rf_dec});
    else n_pass++;
    if (b_ack && exp_q.size() != 0) begin
      c = exp_q.pop_front();
      n_total++;
      if (rf_outAselect !== c.sel) $display("FAIL read_sel got %0d want %0d", rf_outAselect, c.sel);
      else n_pass++;
    end
    exp_q.delete();
    b_req = 1'b0;
    @(negedge clk);
    n_total++;
    if ({a_rvalid, b_rvalid} !== 2'b01)
      $display("FAIL read_rvalid got %b want 01", {a_rvalid, b_rvalid});
    else n_pass++;
    if (b_rvalid && rd_q.size() != 0) begin
      logic [7:0] e;
      e = rd_q.pop_front();
      n_total++;
      if (rdata !== e) $display("FAIL read_data got %h want %h", rdata, e);
      else n_pass++;
    end
    rd_q.delete();
    @(negedge clk);
    n_total++;
    if ({a_rvalid, b_rvalid, rdata} !== {2'b00, 8'hC3})
      $display("FAIL read_hold got %h want 0c3", {a_rvalid, b_rvalid, rdata});
    else n_pass++;
  endtask

  task automatic test_idle_hold();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_total++;
      if ({rf_write_en, rf_inc, rf_dec, a_ack, b_ack, a_rvalid, b_rvalid} !== 7'b0)
        $display("FAIL idle_outputs cycle %0d got %b want 0000000", k,
                 {rf_write_en, rf_inc, rf_dec, a_ack, b_ack, a_rvalid, b_rvalid});
      else n_pass++;
      n_total++;
      if (rdata !== 8'hC3) $display("FAIL idle_rdata cycle %0d got %h want c3", k, rdata);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_issue();
    @(negedge clk);
    a_req = 1'b1; a_op = 2'b00; a_sel = 4'd5; a_wdata = 8'h77;
    @(posedge clk);
    #2;
    n_total++;
    if ({rf_write_en, a_ack} !== 2'b11)
      $display("FAIL midreset_issue got %b want 11", {rf_write_en, a_ack});
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if ({rf_write_en, a_ack, rf_inSelect} !== 6'b0)
      $display("FAIL midreset_async got %b want 000000", {rf_write_en, a_ack, rf_inSelect});
    else n_pass++;
    @(negedge clk);
    a_req = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_total++;
      if ({rf_write_en, rf_inc, rf_dec, a_ack, b_ack, a_rvalid, b_rvalid} !== 7'b0)
        $display("FAIL midreset_after cycle %0d got %b want 0000000", k,
                 {rf_write_en, rf_inc, rf_dec, a_ack, b_ack, a_rvalid, b_rvalid});
      else n_pass++;
    end
  endtask

  task automatic test_withdrawn();
    @(negedge clk);
    a_req = 1'b1; a_op = 2'b00; a_sel = 4'd9; a_wdata = 8'hAA;
    #2;
    a_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_total++;
      if ({rf_write_en, rf_inc, rf_dec, a_ack, b_ack} !== 5'b0)
        $display("FAIL withdrawn cycle %0d got %b want 00000", k,
                 {rf_write_en, rf_inc, rf_dec, a_ack, b_ack});
      else n_pass++;
    end
    n_total++;
    if (rf_mem[9] !== 8'h00) $display("FAIL withdrawn_mem got %h want 00", rf_mem[9]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_write();
    test_read();
    test_idle_hold();
    test_reset_mid_issue();
    test_withdrawn();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
